accel_host_loader: RTL and testbench
====================================

Name: accel_host_loader

Overview:
- Host-side initiator for the accelerator memory-load/run interface; replaces hand-scripted bench stimulus with a command-driven engine.
- Accepts a command stream plus a write-data stream and drives the accelerator's `mem_ctrl_in`, `mem_data_input`, `mem_rd_wrt` and `start`.
- Loads the instruction, data, weight and meta namespaces, launches a run and waits for `eoc`, then reads results back from `mem_data_output` onto a valid/ready stream.
- Sits between the host/DMA fabric and the accelerator top.

Parameters:
- logNumPu, 3, log2 of processing units
- logNumPe, 3, log2 of PEs per PU
- memDataLen, 16, bits per memory column
- logMemNamespaces, 2, namespace select width (0 instruction, 1 data, 2 weight, 3 meta)
- logNumMemColumns, 4, log2 of memory columns
- rdLatency, 1, cycles from read beat to valid `mem_data_output` (>=1)
- timeoutCycles, 65535, run watchdog limit; 0 disables the watchdog
- Derived: numMemColumns = 1<<logNumMemColumns; logNumPeMemColumn = logNumPu+logNumPe-logNumMemColumns; memCtrlIn = logMemNamespaces+(logNumPeMemColumn+1)*numMemColumns

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  00 WRITE, 01 READ, 10 RUN, 11 NOP
- cmd_ns  in  logMemNamespaces  target namespace
- cmd_pe  in  logNumPeMemColumn  PE index within column
- cmd_col_mask  in  numMemColumns  column enables
- cmd_len  in  16  beats for WRITE/READ
- wr_valid / wr_ready  in/out  1  write-data handshake
- wr_data  in  memDataLen*numMemColumns  write beat
- rd_valid / rd_ready  out/in  1  read-data handshake
- rd_data  out  memDataLen*numMemColumns  read beat
- mem_rd_wrt  out  1  0 write, 1 read
- mem_ctrl_in  out  memCtrlIn  namespace + per-column fields
- mem_data_input  out  memDataLen*numMemColumns  write data
- mem_data_output  in  memDataLen*numMemColumns  read data
- start  out  1  run pulse
- eol, eoc  in  1  end-of-loop / end-of-compute from accelerator
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse per completed command
- timeout_err  out  1  sticky; cleared when the next command is accepted
- eol_count  out  16  eol pulses seen in the last RUN; saturating

Behaviour:
- Reset (async, active-low): all outputs 0, rd_data 0, state IDLE, counters 0.
- Reset asserted mid-operation aborts the command immediately; no partial state survives.
- mem_ctrl_in layout:
  - bits [logMemNamespaces-1:0] = namespace.
  - column c field at offset logMemNamespaces+c*(logNumPeMemColumn+1) = {pe_index, col_en}, col_en in the LSB.
  - Example: ns=1, pe=0, column 0 only gives 'b101.
- All accelerator-side outputs are registered.
- mem_ctrl_in = 0 and mem_rd_wrt = 0 whenever no beat is issued (bubbles, IDLE).
- States: IDLE, WRITE, READ_ISSUE, READ_WAIT, START, RUN.
- IDLE:
  - cmd_ready=1; accept on cmd_valid.
  - WRITE/READ with cmd_len=0: done next cycle, remain IDLE.
  - NOP: done next cycle.
  - Otherwise latch the command fields and go to WRITE, READ_ISSUE or START.
- WRITE:
  - wr_ready=1.
  - Each wr_valid&wr_ready handshake drives, next cycle, mem_data_input=wr_data and mem_ctrl_in with col_en=cmd_col_mask, namespace=cmd_ns; decrement the beat counter.
  - Cycles without wr_valid issue a bubble.
  - After the last beat: done pulse, return to IDLE.
- READ_ISSUE:
  - Enter only when rd_valid=0.
  - Drive mem_rd_wrt=1 and mem_ctrl_in for one cycle, then go to READ_WAIT.
- READ_WAIT:
  - After rdLatency cycles, capture mem_data_output into rd_data and set rd_valid.
  - rd_valid holds, with rd_data stable, until rd_ready.
  - Only one read is outstanding at a time.
  - After the handshake: if beats remain, go to READ_ISSUE; else done and IDLE.
- START:
  - start=1 for exactly one cycle; clear eol_count and the watchdog; go to RUN.
- RUN:
  - Count eol pulses (saturate at 16'hFFFF).
  - On eoc: done, go to IDLE.
  - If the watchdog reaches timeoutCycles (nonzero) before eoc: set timeout_err, done, go to IDLE.
  - eoc in the same cycle as the final watchdog count counts as success.
- eoc/eol outside RUN are ignored.
- cmd_ready=0 in all non-IDLE states.

Decomposition:
- Shared package accel_host_pkg holds:
  - opcode constants;
  - state encoding;
  - memCtrlIn width function;
  - column-field offset function.
- One combinational sub-module, accel_ctrl_word_builder (ns, pe, col_mask, beat_en → mem_ctrl_in), reusable by future readback/debug blocks.

Test Plan:
- Reset mid-WRITE: assert reset during beat 3 of 5 → all outputs 0 immediately; next command starts cleanly.
- WRITE ns=0, pe=0, mask=16'h0001, len=5, wr_data 0,16'h4010,0,0,16'h000A with a 2-cycle wr_valid gap → exactly 5 beats with mem_ctrl_in='b100, bubbles show mem_ctrl_in=0, one done pulse.
- WRITE ns=2, pe=1, mask=16'h0001, len=1 → mem_ctrl_in='b1110 for one cycle, mem_rd_wrt=0.
- READ ns=2, len=3, rdLatency=1, rd_ready held low 4 cycles on beat 2 → exactly 3 read pulses (mem_rd_wrt=1); rd_data matches the model; no issue while rd_valid is high.
- RUN with eol pulsed 3× then eoc 40 cycles after start → start high 1 cycle, eol_count=3, done, timeout_err=0.
- RUN with timeoutCycles=20, no eoc → timeout_err=1 at cycle 20, IDLE; the next accepted command clears it.

Source files
------------

// File: rtl/accel_host_pkg.sv
// Shared definitions for the accelerator host loader: opcodes, FSM state
// encoding and the mem_ctrl_in layout helpers.
package accel_host_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ_ISSUE = 3'd2,
    ST_READ_WAIT  = 3'd3,
    ST_START      = 3'd4,
    ST_RUN        = 3'd5
  } state_e;

  // Total mem_ctrl_in width: namespace bits plus one {pe, col_en} field per column
  function automatic int mem_ctrl_width(input int log_ns, input int log_pe_col, input int num_cols);
    return log_ns + (log_pe_col + 1) * num_cols;
  endfunction

  // Bit offset of the {pe, col_en} field belonging to column col
  function automatic int col_field_offset(input int log_ns, input int log_pe_col, input int col);
    return log_ns + col * (log_pe_col + 1);
  endfunction

endpackage

// File: rtl/accel_ctrl_word_builder.sv
// Packs namespace, PE index and column enables into the accelerator's
// mem_ctrl_in word. Output is all-zero when no beat is being issued, so
// callers can register it directly and get clean bubbles.
module accel_ctrl_word_builder
  import accel_host_pkg::*;
#(
  parameter int logMemNamespaces  = 2,
  parameter int logNumPeMemColumn = 2,
  parameter int numMemColumns     = 16,
  localparam int memCtrlIn = mem_ctrl_width(logMemNamespaces, logNumPeMemColumn, numMemColumns)
) (
  input  logic [logMemNamespaces-1:0]  ns,
  input  logic [logNumPeMemColumn-1:0] pe,
  input  logic [numMemColumns-1:0]     col_mask,
  input  logic                         beat_en,
  output logic [memCtrlIn-1:0]         ctrl_word
);

  // Assemble the control word; disabled columns carry an all-zero field
  always_comb begin
    ctrl_word = '0;
    if (beat_en) begin
      ctrl_word[logMemNamespaces-1:0] = ns;
      for (int c = 0; c < numMemColumns; c++) begin
        if (col_mask[c]) begin
          ctrl_word[col_field_offset(logMemNamespaces, logNumPeMemColumn, c) +: (logNumPeMemColumn + 1)] = {pe, 1'b1};
        end else begin
          ctrl_word[col_field_offset(logMemNamespaces, logNumPeMemColumn, c) +: (logNumPeMemColumn + 1)] = '0;
        end
      end
    end else begin
      ctrl_word = '0;
    end
  end

endmodule

// File: rtl/accel_host_loader.sv
// Command-driven host initiator for the accelerator memory-load/run port.
// Streams write beats into the instruction/data/weight/meta namespaces,
// launches a run and waits for eoc (with an optional watchdog), and reads
// results back one beat at a time onto a valid/ready stream.
module accel_host_loader
  import accel_host_pkg::*;
#(
  parameter int logNumPu         = 3,
  parameter int logNumPe         = 3,
  parameter int memDataLen       = 16,
  parameter int logMemNamespaces = 2,
  parameter int logNumMemColumns = 4,
  parameter int rdLatency        = 1,
  parameter int timeoutCycles    = 65535,
  localparam int numMemColumns     = 1 << logNumMemColumns,
  localparam int logNumPeMemColumn = logNumPu + logNumPe - logNumMemColumns,
  localparam int memCtrlIn         = mem_ctrl_width(logMemNamespaces, logNumPeMemColumn, numMemColumns),
  localparam int dataW             = memDataLen * numMemColumns
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [logMemNamespaces-1:0]  cmd_ns,
  input  logic [logNumPeMemColumn-1:0] cmd_pe,
  input  logic [numMemColumns-1:0]     cmd_col_mask,
  input  logic [15:0]                  cmd_len,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [dataW-1:0]             wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [dataW-1:0]             rd_data,
  output logic                         mem_rd_wrt,
  output logic [memCtrlIn-1:0]         mem_ctrl_in,
  output logic [dataW-1:0]             mem_data_input,
  input  logic [dataW-1:0]             mem_data_output,
  output logic                         start,
  input  logic                         eol,
  input  logic                         eoc,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic [15:0]                  eol_count
);

  localparam logic [7:0]  RD_LAT  = 8'(rdLatency);
  localparam bit          WD_EN   = (timeoutCycles != 0);
  localparam logic [31:0] WD_LAST = (timeoutCycles > 0) ? 32'(timeoutCycles - 1) : 32'd0;

  state_e                         state_r, state_nxt_s;
  logic                           cmd_ready_r, wr_ready_r, busy_r, done_r;
  logic [logMemNamespaces-1:0]    ns_r;
  logic [logNumPeMemColumn-1:0]   pe_r;
  logic [numMemColumns-1:0]       mask_r;
  logic [15:0]                    beats_r;
  logic [7:0]                     wait_cnt_r;
  logic                           rd_valid_r;
  logic [dataW-1:0]               rd_data_r;
  logic                           mem_rd_wrt_r;
  logic [memCtrlIn-1:0]           mem_ctrl_in_r;
  logic [dataW-1:0]               mem_data_input_r;
  logic                           start_r;
  logic [15:0]                    eol_count_r;
  logic [31:0]                    wd_cnt_r;
  logic                           timeout_err_r;

  logic                           accept_s, done_nxt_s, wr_fire_s, rd_issue_s;
  logic                           rd_capture_s, rd_fire_s, timeout_hit_s;
  logic [memCtrlIn-1:0]           ctrl_word_s;

  // cmd_ready is only ever high while IDLE, so this is the IDLE accept strobe
  assign accept_s = cmd_valid & cmd_ready_r;

  accel_ctrl_word_builder #(
    .logMemNamespaces  (logMemNamespaces),
    .logNumPeMemColumn (logNumPeMemColumn),
    .numMemColumns     (numMemColumns)
  ) u_ctrl_word (
    .ns        (ns_r),
    .pe        (pe_r),
    .col_mask  (mask_r),
    .beat_en   (wr_fire_s | rd_issue_s),
    .ctrl_word (ctrl_word_s)
  );

  // Next-state decode and per-cycle event strobes
  always_comb begin
    state_nxt_s   = state_r;
    done_nxt_s    = 1'b0;
    wr_fire_s     = 1'b0;
    rd_issue_s    = 1'b0;
    rd_capture_s  = 1'b0;
    rd_fire_s     = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_WRITE: begin
              if (cmd_len == 16'd0) begin
                done_nxt_s = 1'b1;
              end else begin
                state_nxt_s = ST_WRITE;
              end
            end
            OP_READ: begin
              if (cmd_len == 16'd0) begin
                done_nxt_s = 1'b1;
              end else begin
                state_nxt_s = ST_READ_ISSUE;
              end
            end
            OP_RUN:  state_nxt_s = ST_START;
            OP_NOP:  done_nxt_s  = 1'b1;
            default: done_nxt_s  = 1'b1;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_valid && wr_ready_r) begin
          wr_fire_s = 1'b1;
          if (beats_r == 16'd1) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ_ISSUE: begin
        // Never put a new read on the bus while the previous beat is unconsumed
        if (!rd_valid_r) begin
          rd_issue_s  = 1'b1;
          state_nxt_s = ST_READ_WAIT;
        end else begin
          state_nxt_s = ST_READ_ISSUE;
        end
      end
      ST_READ_WAIT: begin
        if (rd_valid_r) begin
          if (rd_ready) begin
            rd_fire_s = 1'b1;
            if (beats_r == 16'd1) begin
              done_nxt_s  = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_READ_ISSUE;
            end
          end else begin
            state_nxt_s = ST_READ_WAIT;
          end
        end else if (wait_cnt_r == RD_LAT) begin
          rd_capture_s = 1'b1;
        end else begin
          state_nxt_s = ST_READ_WAIT;
        end
      end
      ST_START: state_nxt_s = ST_RUN;
      ST_RUN: begin
        // eoc wins over a watchdog expiry landing in the same cycle
        if (eoc) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (WD_EN && (wd_cnt_r == WD_LAST)) begin
          timeout_hit_s = 1'b1;
          done_nxt_s    = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus host-side handshake/status flags derived from next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      wr_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      wr_ready_r  <= (state_nxt_s == ST_WRITE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= done_nxt_s;
    end
  end

  // Latch command fields on accept and count down remaining beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ns_r    <= '0;
      pe_r    <= '0;
      mask_r  <= '0;
      beats_r <= 16'd0;
    end else if (accept_s) begin
      ns_r    <= cmd_ns;
      pe_r    <= cmd_pe;
      mask_r  <= cmd_col_mask;
      beats_r <= cmd_len;
    end else if (wr_fire_s || rd_fire_s) begin
      beats_r <= beats_r - 16'd1;
    end else begin
      beats_r <= beats_r;
    end
  end

  // Read latency counter and the single-entry read-return holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= 8'd0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      if (rd_issue_s) begin
        wait_cnt_r <= 8'd0;
      end else if ((state_r == ST_READ_WAIT) && !rd_valid_r && (wait_cnt_r != RD_LAT)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (rd_capture_s) begin
        rd_valid_r <= 1'b1;
        rd_data_r  <= mem_data_output;
      end else if (rd_fire_s) begin
        rd_valid_r <= 1'b0;
      end else begin
        rd_valid_r <= rd_valid_r;
      end
    end
  end

  // Registered accelerator-side drive; everything returns to zero between beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd_wrt_r     <= 1'b0;
      mem_ctrl_in_r    <= '0;
      mem_data_input_r <= '0;
      start_r          <= 1'b0;
    end else begin
      mem_rd_wrt_r     <= rd_issue_s;
      mem_ctrl_in_r    <= ctrl_word_s;
      mem_data_input_r <= wr_fire_s ? wr_data : '0;
      start_r          <= (state_r == ST_START);
    end
  end

  // Run bookkeeping: eol counter, watchdog and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eol_count_r   <= 16'd0;
      wd_cnt_r      <= 32'd0;
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r == ST_START) begin
        eol_count_r <= 16'd0;
        wd_cnt_r    <= 32'd0;
      end else if (state_r == ST_RUN) begin
        if (eol && (eol_count_r != 16'hFFFF)) begin
          eol_count_r <= eol_count_r + 16'd1;
        end else begin
          eol_count_r <= eol_count_r;
        end
        if (wd_cnt_r != 32'hFFFF_FFFF) begin
          wd_cnt_r <= wd_cnt_r + 32'd1;
        end else begin
          wd_cnt_r <= wd_cnt_r;
        end
      end else begin
        eol_count_r <= eol_count_r;
        wd_cnt_r    <= wd_cnt_r;
      end
      if (accept_s) begin
        timeout_err_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  assign cmd_ready      = cmd_ready_r;
  assign wr_ready       = wr_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign rd_valid       = rd_valid_r;
  assign rd_data        = rd_data_r;
  assign mem_rd_wrt     = mem_rd_wrt_r;
  assign mem_ctrl_in    = mem_ctrl_in_r;
  assign mem_data_input = mem_data_input_r;
  assign start          = start_r;
  assign eol_count      = eol_count_r;
  assign timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_accel_host_loader.sv
// Directed self-checking bench for accel_host_loader. A second instance with
// a 20-cycle watchdog covers the timeout path.
module tb_accel_host_loader;

  localparam int DW = 256;
  localparam int CW = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [1:0] cmd_op = 2'b11;
  logic [1:0] cmd_ns = 2'd0;
  logic [1:0] cmd_pe = 2'd0;
  logic [15:0] cmd_col_mask = 16'd0;
  logic [15:0] cmd_len = 16'd0;
  logic wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic rd_ready = 1'b1;
  logic [DW-1:0] mem_data_output = '0;
  logic eol = 1'b0, eoc = 1'b0;
  logic wr_valid2 = 1'b0, rd_ready2 = 1'b1, eoc2 = 1'b0;

  logic cmd_ready, wr_ready, rd_valid, mem_rd_wrt, start, busy, done, timeout_err;
  logic [DW-1:0] rd_data, mem_data_input;
  logic [CW-1:0] mem_ctrl_in;
  logic [15:0] eol_count;

  logic cmd_ready2, wr_ready2, rd_valid2, mem_rd_wrt2, start2, busy2, done2, timeout_err2;
  logic [DW-1:0] rd_data2, mem_data_input2;
  logic [CW-1:0] mem_ctrl_in2;
  logic [15:0] eol_count2;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor process)
  int wr_beats = 0, rd_pulses = 0, overlaps = 0, done_cnt = 0, start_cnt = 0;
  logic [CW-1:0] wr_ctrl_log [0:63];
  logic [DW-1:0] wr_data_log [0:63];
  logic [CW-1:0] last_rd_ctrl = '0;

  accel_host_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ns(cmd_ns),
    .cmd_pe(cmd_pe), .cmd_col_mask(cmd_col_mask), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_rd_wrt(mem_rd_wrt), .mem_ctrl_in(mem_ctrl_in), .mem_data_input(mem_data_input),
    .mem_data_output(mem_data_output), .start(start), .eol(eol), .eoc(eoc),
    .busy(busy), .done(done), .timeout_err(timeout_err), .eol_count(eol_count)
  );

  accel_host_loader #(.timeoutCycles(20)) dut_wd (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op), .cmd_ns(cmd_ns),
    .cmd_pe(cmd_pe), .cmd_col_mask(cmd_col_mask), .cmd_len(cmd_len),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data),
    .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_data(rd_data2),
    .mem_rd_wrt(mem_rd_wrt2), .mem_ctrl_in(mem_ctrl_in2), .mem_data_input(mem_data_input2),
    .mem_data_output(mem_data_output), .start(start2), .eol(eol), .eoc(eoc2),
    .busy(busy2), .done(done2), .timeout_err(timeout_err2), .eol_count(eol_count2)
  );

  always #5 clk = ~clk;

  // Expected read-back pattern for the i-th read pulse seen on the bus
  function automatic logic [DW-1:0] rd_pat(input int i);
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < 16; c++) v[c*16 +: 16] = 16'hA000 + 16'(i * 16 + c);
    return v;
  endfunction

  // Memory model with one-cycle read latency plus bus monitors
  always @(posedge clk) begin
    if (mem_rd_wrt) begin
      mem_data_output <= rd_pat(rd_pulses);
      rd_pulses <= rd_pulses + 1;
      last_rd_ctrl <= mem_ctrl_in;
      if (rd_valid) overlaps <= overlaps + 1;
    end else begin
      mem_data_output <= {16{16'hDEAD}};
    end
    if (mem_ctrl_in != '0 && !mem_rd_wrt) begin
      wr_ctrl_log[wr_beats % 64] <= mem_ctrl_in;
      wr_data_log[wr_beats % 64] <= mem_data_input;
      wr_beats <= wr_beats + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [1:0] ns, input logic [1:0] pe,
                           input logic [15:0] mask, input logic [15:0] len);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_ns = ns; cmd_pe = pe; cmd_col_mask = mask; cmd_len = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drive_wr(input logic v, input logic [15:0] d);
    wr_valid = v;
    wr_data = {240'd0, d};
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base, n, sbase, dbase;
    logic [15:0] wvals [0:4];
    wvals[0] = 16'h0000; wvals[1] = 16'h4010; wvals[2] = 16'h0000;
    wvals[3] = 16'h0000; wvals[4] = 16'h000A;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_flags", {cmd_ready, wr_ready, rd_valid, busy, done, start, timeout_err, mem_rd_wrt}, 8'h00);
    chk("rst_ctrl", mem_ctrl_in, '0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_eol_count", eol_count, 16'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Reset mid-WRITE, during beat 3 of 5
    issue_cmd(2'b00, 2'd1, 2'd0, 16'h0001, 16'd5);
    wr_valid = 1'b1; wr_data = {240'd0, 16'h5555};
    repeat (3) @(negedge clk);
    chk("midwr_beat3_ctrl", mem_ctrl_in, 50'b101);
    #2 reset = 1'b0;
    #1;
    chk("midrst_flags", {cmd_ready, wr_ready, rd_valid, busy, done, start, timeout_err, mem_rd_wrt}, 8'h00);
    chk("midrst_ctrl", mem_ctrl_in, '0);
    chk("midrst_wdata", mem_data_input, '0);
    wr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_idle", {cmd_ready, busy}, 2'b10);

    // WRITE 5 beats with a 2-cycle wr_valid gap
    base = wr_beats; dbase = done_cnt;
    issue_cmd(2'b00, 2'd0, 2'd0, 16'h0001, 16'd5);
    drive_wr(1'b1, wvals[0]);
    drive_wr(1'b1, wvals[1]);
    drive_wr(1'b0, 16'h0000);
    chk("wr_bubble_ctrl", mem_ctrl_in, '0);
    drive_wr(1'b0, 16'h0000);
    drive_wr(1'b1, wvals[2]);
    drive_wr(1'b1, wvals[3]);
    drive_wr(1'b1, wvals[4]);
    wr_valid = 1'b0;
    chk("wr5_done", done, 1'b1);
    @(negedge clk);
    chk("wr5_idle", {done, busy}, 2'b00);
    chk("wr5_beats", wr_beats - base, 5);
    chk("wr5_done_cnt", done_cnt - dbase, 1);
    for (int i = 0; i < 5; i++) begin
      chk("wr5_ctrl", wr_ctrl_log[(base + i) % 64], 50'b100);
      chk("wr5_data", wr_data_log[(base + i) % 64], {240'd0, wvals[i]});
    end

    // WRITE ns=2 pe=1 single beat
    issue_cmd(2'b00, 2'd2, 2'd1, 16'h0001, 16'd1);
    drive_wr(1'b1, 16'h1234);
    wr_valid = 1'b0;
    chk("wr1_ctrl", mem_ctrl_in, 50'b1110);
    chk("wr1_rd_wrt", mem_rd_wrt, 1'b0);
    chk("wr1_data", mem_data_input, {240'd0, 16'h1234});
    chk("wr1_done", done, 1'b1);
    @(negedge clk);
    chk("wr1_after_ctrl", mem_ctrl_in, '0);

    // Zero-length WRITE completes immediately
    issue_cmd(2'b00, 2'd0, 2'd0, 16'h0001, 16'd0);
    chk("wr0_done", {done, busy}, 2'b10);

    // READ 3 beats, ns=2, columns 0 and 1, rd_ready low 4 cycles on beat 2
    base = rd_pulses; n = overlaps;
    issue_cmd(2'b01, 2'd2, 2'd0, 16'h0003, 16'd3);
    for (int i = 0; i < 3; i++) begin
      int w;
      rd_ready = (i != 1);
      w = 0;
      while (rd_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      chk("rd_valid_wait", rd_valid, 1'b1);
      chk("rd_data", rd_data, rd_pat(base + i));
      if (i == 1) begin
        repeat (4) @(negedge clk);
        chk("rd_hold", {rd_valid, busy}, 2'b11);
        chk("rd_hold_data", rd_data, rd_pat(base + 1));
        rd_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("rd_done", {done, rd_valid}, 2'b10);
    chk("rd_pulses", rd_pulses - base, 3);
    chk("rd_no_overlap", overlaps - n, 0);
    chk("rd_ctrl", last_rd_ctrl, 50'h26);

    // RUN: 3 eol pulses, eoc about 40 cycles after start
    sbase = start_cnt;
    issue_cmd(2'b10, 2'd0, 2'd0, 16'h0000, 16'd0);
    @(negedge clk);
    chk("run_start", {start, busy}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      eol = 1'b1; @(negedge clk);
      eol = 1'b0; @(negedge clk);
    end
    repeat (33) @(negedge clk);
    chk("run_busy", {busy, done}, 2'b10);
    eoc = 1'b1; @(negedge clk); eoc = 1'b0;
    chk("run_done", {done, busy, timeout_err}, 3'b100);
    chk("run_eol_count", eol_count, 16'd3);
    chk("run_start_cnt", start_cnt - sbase, 1);
    eol = 1'b1; @(negedge clk); eol = 1'b0;
    eoc = 1'b1; @(negedge clk); eoc = 1'b0;
    chk("idle_eol_ignored", eol_count, 16'd3);
    chk("idle_eoc_ignored", {done, busy}, 2'b00);

    // Watchdog on the 20-cycle instance
    cmd_op = 2'b10; cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    repeat (20) @(negedge clk);
    chk("wd_before", {timeout_err2, busy2, done2}, 3'b010);
    @(negedge clk);
    chk("wd_fire", {timeout_err2, busy2, done2}, 3'b101);
    @(negedge clk);
    chk("wd_sticky", {timeout_err2, done2}, 2'b10);
    cmd_op = 2'b11; cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    chk("wd_clear", {timeout_err2, done2}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
